// File: rtl/mux4to1_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux4to1_rr_if
//  Description : Bundle of the four valid/ready source channels and the single
//                merged valid/ready sink channel of the 4-to-1 merger.
//                master = side that drives sources and sink-ready,
//                slave  = the merger itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux4to1_rr_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic             v0, v1, v2, v3;
    logic             r0, r1, r2, r3;
    logic [WIDTH-1:0] y;
    logic [1:0]       sel;
    logic             y_valid;
    logic             y_ready;

    modport master (
        output d0, d1, d2, d3,
        output v0, v1, v2, v3,
        input  r0, r1, r2, r3,
        input  y, sel, y_valid,
        output y_ready
    );

    modport slave (
        input  d0, d1, d2, d3,
        input  v0, v1, v2, v3,
        output r0, r1, r2, r3,
        output y, sel, y_valid,
        input  y_ready
    );
endinterface
`default_nettype wire

// File: rtl/mux4to1_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mux4to1_rr
//  Description : Merges four valid/ready source channels into one registered
//                output channel. Round-robin arbitration by default; define
//                MUX4TO1_FIXED_PRIO_EN for fixed priority (channel 0 highest).
//  Revision    : 1.0 - initial release
// ============================================================================
module mux4to1_rr #(
    parameter int WIDTH = 8
) (
    input  wire              clk,
    input  wire              rst,
    mux4to1_rr_if.slave      bus
);

    localparam logic [1:0] c_PTR_RST = 2'd3;  // channel 0 is first in line

    logic [3:0]       w_valid;
    logic [3:0]       w_ready;
    logic             w_load_en;
    logic             w_gnt_vld;
    logic [1:0]       w_gnt;
    logic [WIDTH-1:0] w_data;

    logic [WIDTH-1:0] r_y;
    logic [1:0]       r_sel;
    logic             r_y_valid;

    assign w_valid   = {bus.v3, bus.v2, bus.v1, bus.v0};
    assign w_load_en = ~r_y_valid | bus.y_ready;

`ifdef MUX4TO1_FIXED_PRIO_EN
    // Fixed priority: lowest-numbered valid channel wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_valid[k]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = 2'(k);
            end
        end
    end
`else
    logic [1:0] r_ptr;  // last channel granted

    // Round-robin: search ptr+1 .. ptr+4; the lowest offset found wins.
    always_comb begin
        logic [1:0] w_idx;
        w_gnt_vld = 1'b0;
        w_gnt     = 2'd0;
        w_idx     = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    // Pointer moves only when a word is actually accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= c_PTR_RST;
        end else if (w_load_en && w_gnt_vld) begin
            r_ptr <= w_gnt;
        end
    end
`endif

    // One-hot ready towards the granted source, held low in reset.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ready
            assign w_ready[gi] = ~rst & w_load_en & w_gnt_vld & (w_gnt == 2'(gi));
        end
    endgenerate

    // Data steering from the granted channel.
    always_comb begin
        case (w_gnt)
            2'd0:    w_data = bus.d0;
            2'd1:    w_data = bus.d1;
            2'd2:    w_data = bus.d2;
            default: w_data = bus.d3;
        endcase
    end

    // Output register: load on grant, empty on drain with no grant, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= '0;
            r_sel     <= 2'd0;
            r_y_valid <= 1'b0;
        end else if (w_load_en) begin
            if (w_gnt_vld) begin
                r_y       <= w_data;
                r_sel     <= w_gnt;
                r_y_valid <= 1'b1;
            end else begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign bus.r0      = w_ready[0];
    assign bus.r1      = w_ready[1];
    assign bus.r2      = w_ready[2];
    assign bus.r3      = w_ready[3];
    assign bus.y       = r_y;
    assign bus.sel     = r_sel;
    assign bus.y_valid = r_y_valid;

endmodule
`default_nettype wire
